// File: rtl/harmonic_mix_sequencer.sv
// Frame sequencer for the scaled-sample adder: clears it, feeds one sample and decaying
// multiple per harmonic, then shifts and saturates the accumulated total into a 16-bit mix.
module harmonic_mix_sequencer #(
  parameter  int DIVISOR_BITS  = 7,
  parameter  int MAX_HARMONICS = 64,
  parameter  int ADDER_LATENCY = 2,
  parameter  int OUT_SHIFT     = 0,
  localparam int HB            = $clog2(MAX_HARMONICS)
) (
  input  logic                           i_Clock,
  input  logic                           i_Reset_n,
  input  logic                           i_Sample_Tick,
  input  logic        [HB:0]             i_Harmonic_Count,
  input  logic        [DIVISOR_BITS-2:0] i_Decay,
  output logic        [HB-1:0]           o_Harmonic,
  output logic                           o_Sample_Req,
  input  logic                           i_Sample_Valid,
  input  logic signed [15:0]             i_Sample,
  output logic                           o_Clear_Accumulator,
  output logic                           o_Start,
  output logic signed [DIVISOR_BITS-1:0] o_Multiple,
  output logic signed [15:0]             o_Sample,
  input  logic                           i_Done,
  input  logic signed [31:0]             i_Accumulator,
  output logic signed [15:0]             o_Mix,
  output logic                           o_Mix_Valid,
  output logic                           o_Busy,
  output logic                           o_Overrun
);

  localparam int MW = DIVISOR_BITS - 1;
  localparam int PW = 2 * MW;
  localparam int WW = (ADDER_LATENCY < 1) ? 1 : $clog2(ADDER_LATENCY + 1);
  localparam logic [MW-1:0] MULT_MAX = '1;
  localparam logic [WW-1:0] LAT_W    = WW'(ADDER_LATENCY);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_REQ, S_START, S_WAIT_ADD, S_DRAIN, S_OUTPUT
  } state_t;

  state_t                   state_q;
  logic        [HB:0]       count_q;
  logic        [MW-1:0]     decay_q;
  logic        [MW-1:0]     mult_q;
  logic        [HB-1:0]     harm_q;
  logic        [WW-1:0]     wait_q;
  logic signed [MW:0]       mult_out_q;
  logic signed [15:0]       sample_q;
  logic signed [15:0]       mix_q;
  logic                     req_q, clear_q, start_q, mix_vld_q, busy_q, overrun_q;

  logic        [MW-1:0]     next_mult_d;
  logic                     last_d;
  logic signed [31:0]       shifted_d;

  function automatic logic [HB:0] clamp_count(input logic [HB:0] c);
    if (c == '0) return (HB+1)'(1);
    if (c > (HB+1)'(MAX_HARMONICS)) return (HB+1)'(MAX_HARMONICS);
    return c;
  endfunction

  function automatic logic signed [15:0] sat16(input logic signed [31:0] v);
    if (v > 32'sd32767) return 16'sh7FFF;
    if (v < -32'sd32768) return 16'sh8000;
    return v[15:0];
  endfunction

  // Multiple is always positive, so it is carried as a magnitude; the product is truncated.
  always_comb begin
    next_mult_d = MW'((PW'(mult_q) * PW'(decay_q)) >> MW);
    last_d      = (({1'b0, harm_q} + (HB+1)'(1)) == count_q);
    shifted_d   = i_Accumulator >>> OUT_SHIFT;
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      state_q    <= S_IDLE;
      harm_q     <= '0;
      wait_q     <= '0;
      mult_out_q <= '0;
      sample_q   <= '0;
      mix_q      <= '0;
      req_q      <= 1'b0;
      clear_q    <= 1'b0;
      start_q    <= 1'b0;
      mix_vld_q  <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      clear_q   <= 1'b0;
      start_q   <= 1'b0;
      mix_vld_q <= 1'b0;
      // busy_q still covers the o_Mix_Valid cycle, so a tick there is an overrun
      overrun_q <= i_Sample_Tick && busy_q;
      if (mix_vld_q) busy_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_Sample_Tick && !busy_q) begin
            count_q <= clamp_count(i_Harmonic_Count);
            decay_q <= i_Decay;
            harm_q  <= '0;
            mult_q  <= MULT_MAX;
            clear_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          req_q   <= 1'b1;
          state_q <= S_REQ;
        end
        S_REQ: begin
          if (i_Sample_Valid) begin
            sample_q   <= i_Sample;
            mult_out_q <= signed'({1'b0, mult_q});
            req_q      <= 1'b0;
            start_q    <= 1'b1;
            state_q    <= S_START;
          end
        end
        S_START: begin
          wait_q  <= WW'(1);
          state_q <= S_WAIT_ADD;
        end
        S_WAIT_ADD: begin
          if (wait_q >= LAT_W && i_Done) begin
            if (last_d || next_mult_d == '0) begin
              state_q <= S_DRAIN;
            end else begin
              harm_q  <= harm_q + HB'(1);
              mult_q  <= next_mult_d;
              req_q   <= 1'b1;
              state_q <= S_REQ;
            end
          end else if (wait_q < LAT_W) begin
            wait_q <= wait_q + WW'(1);
          end
        end
        S_DRAIN: state_q <= S_OUTPUT;
        S_OUTPUT: begin
          mix_q     <= sat16(shifted_d);
          mix_vld_q <= 1'b1;
          state_q   <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_Harmonic          = harm_q;
  assign o_Sample_Req        = req_q;
  assign o_Clear_Accumulator = clear_q;
  assign o_Start             = start_q;
  assign o_Multiple          = mult_out_q;
  assign o_Sample            = sample_q;
  assign o_Mix               = mix_q;
  assign o_Mix_Valid         = mix_vld_q;
  assign o_Busy              = busy_q;
  assign o_Overrun           = overrun_q;

endmodule

// File: tb/tb_harmonic_mix_sequencer.sv
// Bench for harmonic_mix_sequencer: behavioural scaled-sample adder and sample source,
// directed frames plus randomized frames checked against a frame-level reference model.
module tb_harmonic_mix_sequencer;
  localparam int DB   = 7;
  localparam int MAXH = 64;
  localparam int LAT  = 2;
  localparam int HB   = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n, tick, req, sval, clr, start, done, mix_vld, busy, ovr;
  logic        [HB:0]   hcount;
  logic        [DB-2:0] decay;
  logic        [HB-1:0] harm;
  logic signed [15:0]   s_in, s_out, mix;
  logic signed [DB-1:0] mult;
  logic signed [31:0]   acc;

  harmonic_mix_sequencer #(
    .DIVISOR_BITS(DB), .MAX_HARMONICS(MAXH), .ADDER_LATENCY(LAT), .OUT_SHIFT(0)
  ) dut (
    .i_Clock(clk), .i_Reset_n(rst_n), .i_Sample_Tick(tick), .i_Harmonic_Count(hcount),
    .i_Decay(decay), .o_Harmonic(harm), .o_Sample_Req(req), .i_Sample_Valid(sval),
    .i_Sample(s_in), .o_Clear_Accumulator(clr), .o_Start(start), .o_Multiple(mult),
    .o_Sample(s_out), .i_Done(done), .i_Accumulator(acc), .o_Mix(mix),
    .o_Mix_Valid(mix_vld), .o_Busy(busy), .o_Overrun(ovr)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Sample source: answers a request after src_delay cycles (0 = same cycle).
  int                 src_delay = 0;
  bit                 src_fixed = 1;
  logic signed [15:0] src_val   = 16'sd1000;
  int                 src_cnt   = 0;
  longint             src_q[$];
  always @(negedge clk) begin
    if (!rst_n) begin
      sval = 1'b0; src_cnt = 0;
    end else if (req) begin
      if (src_cnt >= src_delay) begin
        sval = 1'b1;
        s_in = src_fixed ? src_val : 16'($urandom);
        src_q.push_back(s_in);
        src_cnt = 0;
      end else begin
        sval = 1'b0; src_cnt++;
      end
    end else begin
      if (src_cnt > 0) chk("req_held", 0, 1);
      sval = 1'b0; src_cnt = 0;
    end
  end

  // Scaled-sample adder: acc += (sample*multiple) >>> DB, LAT cycles after start (+ add_extra).
  int                 add_extra = 0;
  bit                 acc_force = 0;
  logic signed [31:0] force_val = 0;
  int                 rem = 0;
  logic signed [15:0] a_s;
  logic signed [DB-1:0] a_m;
  always @(negedge clk) begin
    if (!rst_n) begin
      acc = 0; done = 1'b1; rem = 0;
    end else begin
      if (clr) acc = 0;
      if (start) begin
        done = 1'b0; rem = LAT - 1 + add_extra; a_s = s_out; a_m = mult;
      end else if (!done) begin
        if (rem == 0) begin
          acc  = acc + 32'((longint'(a_s) * longint'(a_m)) >>> DB);
          done = 1'b1;
        end else rem--;
      end
      if (acc_force) acc = force_val;
    end
  end

  longint mq[$], hq[$];
  int     n_mixv = 0, n_ovr = 0, max_harm = 0, zero_issue = 0;
  always @(negedge clk) begin
    if (start) begin
      mq.push_back(mult); hq.push_back(harm);
      if (mult == 0) zero_issue++;
    end
    if (rst_n && req && int'(harm) > max_harm) max_harm = int'(harm);
    if (mix_vld) n_mixv++;
    if (ovr) n_ovr++;
  end

  task automatic clear_rec();
    mq.delete(); hq.delete(); src_q.delete();
    n_mixv = 0; n_ovr = 0; max_harm = 0; zero_issue = 0;
  endtask

  int t0, lat, b1, bv, ba;
  task automatic pulse_tick(input int cnt, input int dec);
    @(negedge clk);
    hcount = (HB+1)'(cnt); decay = (DB-1)'(dec); tick = 1'b1; t0 = cyc;
    @(negedge clk);
    tick = 1'b0; b1 = int'(busy);
  endtask

  task automatic wait_mix();
    int w = 0;
    while (!mix_vld && w < 3000) begin @(negedge clk); w++; end
    chk("mix_timeout", mix_vld, 1);
    lat = cyc - t0; bv = int'(busy);
  endtask

  task automatic settle();
    @(negedge clk); ba = int'(busy);
    @(negedge clk);
  endtask

  task automatic run_frame(input int cnt, input int dec);
    pulse_tick(cnt, dec); wait_mix(); settle();
  endtask

  // Reference model: list of multiples a frame issues, and the saturated mix of their terms.
  longint exp_m[$];
  function automatic void model(input int cnt, input int dec);
    int k = (cnt == 0) ? 1 : ((cnt > MAXH) ? MAXH : cnt);
    int m = (1 << (DB - 1)) - 1;
    exp_m.delete();
    for (int h = 0; h < k; h++) begin
      exp_m.push_back(m);
      if ((m * dec) / (1 << (DB - 1)) == 0) break;
      m = (m * dec) / (1 << (DB - 1));
    end
  endfunction

  function automatic longint exp_mix();
    longint s = 0;
    for (int i = 0; i < exp_m.size() && i < src_q.size(); i++)
      s += (src_q[i] * exp_m[i]) >>> DB;
    if (s > 32767) return 32767;
    if (s < -32768) return -32768;
    return s;
  endfunction

  initial begin
    #5ms;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; tick = 1'b0; hcount = '0; decay = '0; sval = 1'b0; s_in = '0;
    acc = 0; done = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_mix", mix, 0);         chk("rst_mix_valid", mix_vld, 0);
    chk("rst_busy", busy, 0);       chk("rst_req", req, 0);
    chk("rst_start", start, 0);     chk("rst_clear", clr, 0);
    chk("rst_mult", mult, 0);       chk("rst_sample", s_out, 0);
    chk("rst_harm", harm, 0);       chk("rst_overrun", ovr, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // single harmonic
    clear_rec(); run_frame(1, 0);
    chk("t1_mix", mix, 492);          chk("t1_latency", lat, 8);
    chk("t1_nstart", mq.size(), 1);   chk("t1_mult", mq[0], 63);
    chk("t1_nvalid", n_mixv, 1);      chk("t1_busy_after_tick", b1, 1);
    chk("t1_busy_valid", bv, 1);      chk("t1_busy_after", ba, 0);

    // geometric decay by one half
    clear_rec(); run_frame(3, 32);
    chk("t2_mix", mix, 851);          chk("t2_latency", lat, 16);
    chk("t2_nstart", mq.size(), 3);
    chk("t2_mult0", mq[0], 63); chk("t2_mult1", mq[1], 31); chk("t2_mult2", mq[2], 15);

    // decay 0 stops after the first harmonic
    clear_rec(); run_frame(8, 0);
    chk("t3_mix", mix, 492);          chk("t3_nstart", mq.size(), 1);
    chk("t3_max_harm", max_harm, 0);

    // saturation both ways
    acc_force = 1; force_val = 40000;
    clear_rec(); run_frame(1, 0);
    chk("t4_sat_hi", mix, 32767);
    force_val = -40000;
    clear_rec(); run_frame(1, 0);
    chk("t4_sat_lo", mix, -32768);
    acc_force = 0;

    // tick mid-frame, tick on the valid cycle, then tick on the first idle cycle
    clear_rec();
    pulse_tick(1, 0);
    repeat (2) @(negedge clk);
    tick = 1'b1; @(negedge clk); tick = 1'b0;
    wait_mix();
    chk("t5_mix_a", mix, 492);
    tick = 1'b1; @(negedge clk);
    @(negedge clk); tick = 1'b0;
    chk("t5_restart_busy", busy, 1);
    wait_mix(); settle();
    chk("t5_overruns", n_ovr, 2);     chk("t5_nvalid", n_mixv, 2);
    chk("t5_mix_b", mix, 492);        chk("t5_nstart", mq.size(), 2);

    // slow sample source
    src_delay = 5;
    clear_rec(); run_frame(1, 0);
    chk("t5_slow_mix", mix, 492);     chk("t5_slow_latency", lat, 13);
    src_delay = 0;

    // reset while waiting on the adder
    clear_rec(); pulse_tick(3, 32);
    begin
      int w = 0;
      while (!start && w < 50) begin @(negedge clk); w++; end
      chk("t6_saw_start", start, 1);
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_busy", busy, 0);   chk("t6_mult", mult, 0);  chk("t6_sample", s_out, 0);
    chk("t6_mix", mix, 0);     chk("t6_req", req, 0);    chk("t6_start", start, 0);
    chk("t6_clear", clr, 0);   chk("t6_valid", mix_vld, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clear_rec(); pulse_tick(3, 32);
    begin
      int w = 0;
      while (!clr && !start && w < 20) begin @(negedge clk); w++; end
      chk("t6_clear_first", clr, 1);  chk("t6_no_start_yet", start, 0);
    end
    wait_mix(); settle();
    chk("t6_mix_after", mix, 851);

    // randomized frames
    src_fixed = 0;
    for (int f = 0; f < 40; f++) begin
      int cnt, dec;
      cnt = $urandom_range(0, 127);
      dec = (f % 3 == 0) ? $urandom_range(56, 63) : $urandom_range(0, 63);
      src_delay = $urandom_range(0, 3);
      add_extra = $urandom_range(0, 2);
      clear_rec(); run_frame(cnt, dec);
      model(cnt, dec);
      chk("rnd_nstart", mq.size(), exp_m.size());
      for (int i = 0; i < mq.size() && i < exp_m.size(); i++) begin
        chk("rnd_mult", mq[i], exp_m[i]);
        chk("rnd_harm", hq[i], i);
      end
      chk("rnd_nsrc", src_q.size(), exp_m.size());
      chk("rnd_mix", mix, exp_mix());
      chk("rnd_nvalid", n_mixv, 1);
      chk("rnd_zero_mult", zero_issue, 0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
